// File: rtl/control_input_stage.sv
// Control-bit input stage: each channel k contributes +Gamma_k when its bit
// is 1 and -Gamma_k when its bit is 0. The complex sum of all channels feeds
// the recursion stage. Two registered stages (sign-applied terms, then the
// adder-tree sum) form an elastic pipeline with valid/ready on both sides.
module control_input_stage #(
   parameter int M  = 4,
   parameter int CW = 16,
   parameter int OW = CW + $clog2(M) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [M-1:0]            in_bits,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    coef_we,
   input  logic [$clog2(M)-1:0]    coef_addr,
   input  logic signed [CW-1:0]    coef_re,
   input  logic signed [CW-1:0]    coef_im,
   output logic signed [OW-1:0]    out_r,
   output logic signed [OW-1:0]    out_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             sample_cnt
);

   logic signed [CW-1:0] r_gamma_re [M];
   logic signed [CW-1:0] r_gamma_im [M];
   logic signed [OW-1:0] r_s1_re [M];
   logic signed [OW-1:0] r_s1_im [M];
   logic                 r_s1_vld;
   logic signed [OW-1:0] r_out_re;
   logic signed [OW-1:0] r_out_im;
   logic                 r_out_vld;
   logic [31:0]          r_cnt;

   logic                 w_adv;
   logic signed [OW-1:0] w_term_re [M];
   logic signed [OW-1:0] w_term_im [M];
   logic signed [OW-1:0] w_sum_re;
   logic signed [OW-1:0] w_sum_im;

   // The whole pipeline moves together; it only stalls when a valid output
   // is waiting on the consumer.
   assign w_adv     = !r_out_vld || out_ready;
   assign in_ready  = w_adv;
   assign out_r     = r_out_re;
   assign out_i     = r_out_im;
   assign out_valid = r_out_vld;
   assign sample_cnt = r_cnt;

   // Sign-extend each coefficient to the full output width before negating,
   // so negating the most negative coefficient is still exact.
   always_comb begin
      for (int k = 0; k < M; k++) begin
         w_term_re[k] = $signed({{(OW-CW){r_gamma_re[k][CW-1]}}, r_gamma_re[k]});
         w_term_im[k] = $signed({{(OW-CW){r_gamma_im[k][CW-1]}}, r_gamma_im[k]});
         if (!in_bits[k]) begin
            w_term_re[k] = -w_term_re[k];
            w_term_im[k] = -w_term_im[k];
         end
      end
   end

   // Adder tree over the registered terms; OW is wide enough that it never wraps.
   always_comb begin
      w_sum_re = '0;
      w_sum_im = '0;
      for (int k = 0; k < M; k++) begin
         w_sum_re = w_sum_re + r_s1_re[k];
         w_sum_im = w_sum_im + r_s1_im[k];
      end
   end

   // Coefficient registers; a sample captured on the same edge still sees the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < M; k++) begin
            r_gamma_re[k] <= '0;
            r_gamma_im[k] <= '0;
         end
      end else if (coef_we) begin
         r_gamma_re[coef_addr] <= coef_re;
         r_gamma_im[coef_addr] <= coef_im;
      end
   end

   // S1 holds the sign-applied terms, S2 the sum; both hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_out_vld <= 1'b0;
         r_out_re  <= '0;
         r_out_im  <= '0;
         for (int k = 0; k < M; k++) begin
            r_s1_re[k] <= '0;
            r_s1_im[k] <= '0;
         end
      end else if (w_adv) begin
         r_s1_vld  <= in_valid;
         r_out_vld <= r_s1_vld;
         if (in_valid) begin
            for (int k = 0; k < M; k++) begin
               r_s1_re[k] <= w_term_re[k];
               r_s1_im[k] <= w_term_im[k];
            end
         end
         if (r_s1_vld) begin
            r_out_re <= w_sum_re;
            r_out_im <= w_sum_im;
         end
      end
   end

   // Delivered-sample counter, wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_out_vld && out_ready) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_control_input_stage.sv
module tb_control_input_stage;

   localparam int M  = 4;
   localparam int CW = 16;
   localparam int OW = CW + $clog2(M) + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [M-1:0]         in_bits;
   logic                 in_valid;
   logic                 in_ready;
   logic                 coef_we;
   logic [1:0]           coef_addr;
   logic signed [CW-1:0] coef_re;
   logic signed [CW-1:0] coef_im;
   logic signed [OW-1:0] out_r;
   logic signed [OW-1:0] out_i;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          sample_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] bits;
      int         er;
      int         ei;
   } vec_t;

   vec_t tbl [8];

   control_input_stage #(.M(M), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .in_bits(in_bits), .in_valid(in_valid), .in_ready(in_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_re(coef_re), .coef_im(coef_im),
      .out_r(out_r), .out_i(out_i), .out_valid(out_valid), .out_ready(out_ready),
      .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input int er, input int ei);
      chk({name, "_valid"}, longint'(out_valid), 1);
      chk({name, "_r"}, longint'(out_r), longint'(er));
      chk({name, "_i"}, longint'(out_i), longint'(ei));
   endtask

   task automatic wr(input int a, input int re, input int im);
      coef_we   = 1'b1;
      coef_addr = a[1:0];
      coef_re   = re[15:0];
      coef_im   = im[15:0];
      tick();
      coef_we   = 1'b0;
   endtask

   initial begin
      // Gamma = (100,-50) (200,0) (-300,25) (1,1)
      tbl[0] = '{4'b1111,    1,  -24};
      tbl[1] = '{4'b0000,   -1,   24};
      tbl[2] = '{4'b0101, -401,  -26};
      tbl[3] = '{4'b1010,  401,   26};
      tbl[4] = '{4'b0001,  199,  -76};
      tbl[5] = '{4'b0010,  399,   24};
      tbl[6] = '{4'b0100, -601,   74};
      tbl[7] = '{4'b1000,    1,   26};

      rst = 1'b1; in_bits = '0; in_valid = 1'b0; coef_we = 1'b0;
      coef_addr = '0; coef_re = '0; coef_im = '0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_r", longint'(out_r), 0);
      chk("rst_out_i", longint'(out_i), 0);
      chk("rst_cnt", longint'(sample_cnt), 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", longint'(in_ready), 1);

      wr(0, 100, -50);
      wr(1, 200, 0);
      wr(2, -300, 25);
      wr(3, 1, 1);

      // Back-to-back stream: output i appears two edges after it is driven.
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            in_bits  = tbl[i].bits;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk("stream_in_ready", longint'(in_ready), 1);
         tick();
         if (i >= 1) chk_out($sformatf("stream%0d", i-1), tbl[i-1].er, tbl[i-1].ei);
      end
      tick();
      chk("stream_drained", longint'(out_valid), 0);
      chk("stream_cnt", longint'(sample_cnt), 8);

      // Backpressure: five stalled cycles with v0 at the output.
      in_bits = tbl[0].bits; in_valid = 1'b1; tick();
      in_bits = tbl[1].bits; tick();
      chk_out("bp_pre", tbl[0].er, tbl[0].ei);
      out_ready = 1'b0;
      in_bits = tbl[2].bits;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_in_ready", longint'(in_ready), 0);
         chk_out("bp_hold", tbl[0].er, tbl[0].ei);
         tick();
      end
      chk_out("bp_hold_end", tbl[0].er, tbl[0].ei);
      chk("bp_cnt_stall", longint'(sample_cnt), 8);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", longint'(in_ready), 1);
      tick();
      chk_out("bp_v1", tbl[1].er, tbl[1].ei);
      in_bits = tbl[3].bits; tick();
      chk_out("bp_v2", tbl[2].er, tbl[2].ei);
      in_valid = 1'b0; tick();
      chk_out("bp_v3", tbl[3].er, tbl[3].ei);
      tick();
      chk("bp_drained", longint'(out_valid), 0);
      chk("bp_cnt", longint'(sample_cnt), 12);

      // Extremes: most negative coefficients everywhere.
      for (int k = 0; k < 4; k++) wr(k, -32768, -32768);
      in_bits = 4'b0000; in_valid = 1'b1; tick();
      in_bits = 4'b1111; tick();
      chk_out("ext_0000", 131072, 131072);
      in_valid = 1'b0; tick();
      chk_out("ext_1111", -131072, -131072);
      tick();

      // Coefficient write on the same edge a sample is accepted.
      in_bits = 4'b0000; in_valid = 1'b1;
      coef_we = 1'b1; coef_addr = 2'd0; coef_re = 16'sd7; coef_im = 16'sd7;
      tick();
      coef_we = 1'b0;
      tick();
      chk_out("coll_old", 131072, 131072);
      in_valid = 1'b0; tick();
      chk_out("coll_new", 98297, 98297);
      tick();

      // Reset with two samples in flight; write and input during reset are dropped.
      in_bits = 4'b1111; in_valid = 1'b1; tick();
      tick();
      chk("rst2_pre_valid", longint'(out_valid), 1);
      rst = 1'b1;
      coef_we = 1'b1; coef_addr = 2'd0; coef_re = 16'sd5; coef_im = 16'sd5;
      tick();
      rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
      chk("rst2_valid", longint'(out_valid), 0);
      chk("rst2_out_r", longint'(out_r), 0);
      chk("rst2_out_i", longint'(out_i), 0);
      chk("rst2_cnt", longint'(sample_cnt), 0);
      #1;
      chk("rst2_in_ready", longint'(in_ready), 1);
      tick();
      chk("rst2_no_ghost", longint'(out_valid), 0);
      in_bits = 4'b0110; in_valid = 1'b1; tick();
      in_valid = 1'b0; tick();
      chk_out("rst2_zero_coef", 0, 0);
      tick();
      chk("rst2_cnt_after", longint'(sample_cnt), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
